// File: rtl/bkg_pkg.sv
// Package: bkg_pkg
// Shared definitions for the background renderer.
//  - Game state codes as driven on the S input.
//  - Fade FSM state encoding.
//  - 24-bit {r,g,b} colour constants.
package bkg_pkg;

    localparam logic [2:0] ST_MENU = 3'b000;
    localparam logic [2:0] ST_ON   = 3'b001;
    localparam logic [2:0] ST_LOSE = 3'b010;
    localparam logic [2:0] ST_WIN  = 3'b011;

    typedef enum logic [1:0] {
        StSteady,
        StFadeOut,
        StFadeIn
    } fade_st_e;

    localparam logic [23:0] BLUE    = 24'h0000FF;
    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] BLACK   = 24'h000000;
    localparam logic [23:0] WIN_YEL = 24'hFFEC00;
    localparam logic [23:0] WHITE   = 24'hFFFFFF;

endpackage

// File: rtl/bkg_renderer_if.sv
// Interface: bkg_renderer_if
// Pixel-stream bundle between the VGA timing / game FSM side and the renderer.
//  master: drives video_on, x_coord, y_coord, S, text_on; receives colours.
//  slave : the renderer; receives pixel context, drives red/green/blue/bkg_rgb.
interface bkg_renderer_if #(
    parameter int unsigned COORD_W = 10
);
    logic               video_on;
    logic [COORD_W-1:0] x_coord;
    logic [COORD_W-1:0] y_coord;
    logic [2:0]         S;
    logic               text_on;
    logic [7:0]         red;
    logic [7:0]         green;
    logic [7:0]         blue;
    logic [23:0]        bkg_rgb;

    modport master (
        output video_on, x_coord, y_coord, S, text_on,
        input  red, green, blue, bkg_rgb
    );

    modport slave (
        input  video_on, x_coord, y_coord, S, text_on,
        output red, green, blue, bkg_rgb
    );
endinterface

// File: rtl/bkg_fade_scaler.sv
// Module: bkg_fade_scaler
// Combinational brightness scaler for one 8-bit colour channel.
//  chan_i  : channel value
//  level_i : brightness, 0 .. 2**FADE_LOG2 (full)
//  chan_o  : (chan_i * level_i) >> FADE_LOG2; full level is exact passthrough
module bkg_fade_scaler #(
    parameter int unsigned FADE_LOG2 = 3
) (
    input  logic [7:0]         chan_i,
    input  logic [FADE_LOG2:0] level_i,
    output logic [7:0]         chan_o
);
    localparam int unsigned PROD_W = 8 + FADE_LOG2 + 1;

    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] shifted;
    logic              unused_hi;

    assign prod    = {{(FADE_LOG2 + 1){1'b0}}, chan_i} * {8'd0, level_i};
    assign shifted = prod >> FADE_LOG2;
    // Max result is 255, so the bits above the low byte are always zero.
    assign unused_hi = ^shifted[PROD_W-1:8];
    assign chan_o    = shifted[7:0];
endmodule

// File: rtl/bkg_renderer.sv
// Module: bkg_renderer
// Per-pixel background/overlay colour generator, one pixel per clk, 1-clk latency.
//  clk : pixel clock
//  rst : synchronous, active-high reset
//  bus : slave side of bkg_renderer_if
//        in : video_on, x_coord, y_coord, S (requested game state), text_on
//        out: red/green/blue (final colour), bkg_rgb (background after fade), all registered
// Colours follow the displayed state (shown_q), which only changes at the dark point of a
// frame-synchronous fade-out/fade-in, so a state change never tears mid-frame.
module bkg_renderer
    import bkg_pkg::*;
#(
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned TOP_BAND  = 85,
    parameter int unsigned BOT_BAND  = 415,
    parameter int unsigned FADE_LOG2 = 3,
    parameter int unsigned BLINK_FRM = 30
) (
    input logic           clk,
    input logic           rst,
    bkg_renderer_if.slave bus
);
    localparam int unsigned LVL_W = FADE_LOG2 + 1;
    localparam int unsigned CNT_W = (BLINK_FRM > 1) ? $clog2(BLINK_FRM) : 1;
    localparam logic [LVL_W-1:0] LVL_FULL = {1'b1, {FADE_LOG2{1'b0}}};
    localparam logic [LVL_W-1:0] LVL_ONE  = {{FADE_LOG2{1'b0}}, 1'b1};

    logic eof;

    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_ph_q, blink_ph_d;

    fade_st_e         state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [2:0]       shown_q, shown_d;

    logic [23:0] bkg_raw;
    logic [23:0] bkg_scaled;
    logic [7:0]  white_scaled;
    logic        text_show;

    logic [23:0] rgb_d, rgb_q;
    logic [23:0] bkg_d, bkg_q;

    // Last active pixel of the frame.
    assign eof = bus.video_on
              && (bus.x_coord == COORD_W'(H_ACTIVE - 1))
              && (bus.y_coord == COORD_W'(V_ACTIVE - 1));

    // Blink counter runs in every state so the phase is free-running.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (eof) begin
            if (blink_cnt_q == CNT_W'(BLINK_FRM - 1)) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end
    end

    // Fade FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StSteady;
            level_q <= LVL_FULL;
            shown_q <= ST_MENU;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            shown_q <= shown_d;
        end
    end

    // Fade FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSteady: begin
                if (eof && (bus.S != shown_q)) state_d = StFadeOut;
            end
            StFadeOut: begin
                if (eof && (level_q == '0)) state_d = StFadeIn;
            end
            StFadeIn: begin
                if (eof && (level_q == LVL_FULL - LVL_ONE)) state_d = StSteady;
            end
            default: state_d = StSteady;
        endcase
    end

    // Fade FSM: level and displayed-state updates.
    always_comb begin
        level_d = level_q;
        shown_d = shown_q;
        unique case (state_q)
            StSteady: begin
                if (eof && (bus.S != shown_q)) level_d = level_q - LVL_ONE;
            end
            StFadeOut: begin
                if (eof) begin
                    if (level_q == '0) begin
                        // Swap at full black; S is sampled here, not at fade start.
                        shown_d = bus.S;
                        level_d = LVL_ONE;
                    end else begin
                        level_d = level_q - LVL_ONE;
                    end
                end
            end
            StFadeIn: begin
                if (eof) level_d = level_q + LVL_ONE;
            end
            default: begin
                level_d = LVL_FULL;
            end
        endcase
    end

    // Background colour from the displayed state.
    always_comb begin
        bkg_raw = BLACK;
        unique case (shown_q)
            ST_MENU: bkg_raw = BLUE;
            ST_ON: begin
                if (bus.y_coord > COORD_W'(BOT_BAND)) begin
                    bkg_raw = RED;
                end else if (bus.y_coord <= COORD_W'(TOP_BAND)) begin
                    bkg_raw = BLUE;
                end else begin
                    bkg_raw = BLACK;
                end
            end
            ST_LOSE: bkg_raw = RED;
            ST_WIN:  bkg_raw = WIN_YEL;
            default: bkg_raw = BLACK;
        endcase
    end

    assign text_show = bus.text_on
                    && ((shown_q == ST_LOSE) || ((shown_q == ST_WIN) && blink_ph_q));

    bkg_fade_scaler #(.FADE_LOG2(FADE_LOG2)) u_scale_r (
        .chan_i  (bkg_raw[23:16]),
        .level_i (level_q),
        .chan_o  (bkg_scaled[23:16])
    );

    bkg_fade_scaler #(.FADE_LOG2(FADE_LOG2)) u_scale_g (
        .chan_i  (bkg_raw[15:8]),
        .level_i (level_q),
        .chan_o  (bkg_scaled[15:8])
    );

    bkg_fade_scaler #(.FADE_LOG2(FADE_LOG2)) u_scale_b (
        .chan_i  (bkg_raw[7:0]),
        .level_i (level_q),
        .chan_o  (bkg_scaled[7:0])
    );

    // Text is white on all three channels, so one scaler covers it.
    bkg_fade_scaler #(.FADE_LOG2(FADE_LOG2)) u_scale_txt (
        .chan_i  (WHITE[7:0]),
        .level_i (level_q),
        .chan_o  (white_scaled)
    );

    always_comb begin
        rgb_d = '0;
        bkg_d = '0;
        if (bus.video_on) begin
            bkg_d = bkg_scaled;
            rgb_d = text_show ? {white_scaled, white_scaled, white_scaled} : bkg_scaled;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            rgb_q       <= '0;
            bkg_q       <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            rgb_q       <= rgb_d;
            bkg_q       <= bkg_d;
        end
    end

    assign bus.red     = rgb_q[23:16];
    assign bus.green   = rgb_q[15:8];
    assign bus.blue    = rgb_q[7:0];
    assign bus.bkg_rgb = bkg_q;

endmodule

// File: tb/tb_bkg_renderer.sv
// Testbench for bkg_renderer: scoreboard of expected pixels pushed at drive time and
// popped one clock later, plus fixed-value checks at the boundaries.
module tb_bkg_renderer;
    import bkg_pkg::*;

    localparam int FL = 3;
    localparam int BF = 2;
    localparam int FULL = 1 << FL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bkg_renderer_if #(.COORD_W(10)) bus ();

    bkg_renderer #(
        .COORD_W   (10),
        .H_ACTIVE  (640),
        .V_ACTIVE  (480),
        .TOP_BAND  (85),
        .BOT_BAND  (415),
        .FADE_LOG2 (FL),
        .BLINK_FRM (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic [23:0] bkg;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state.
    logic [2:0] m_shown;
    int         m_level;
    int         m_phase;  // 0 steady, 1 fading out, 2 fading in
    int         m_bcnt;
    bit         m_bph;

    function automatic logic [7:0] sc(input logic [7:0] c, input int lvl);
        int p;
        p = int'(c) * lvl;
        return 8'(p / FULL);
    endfunction

    function automatic logic [23:0] sc24(input logic [23:0] v, input int lvl);
        return {sc(v[23:16], lvl), sc(v[15:8], lvl), sc(v[7:0], lvl)};
    endfunction

    function automatic logic [23:0] raw_bkg(input logic [2:0] st, input int y);
        case (st)
            3'b000:  return 24'h0000FF;
            3'b001:  return (y > 415) ? 24'hFF0000 : ((y <= 85) ? 24'h0000FF : 24'h000000);
            3'b010:  return 24'hFF0000;
            3'b011:  return 24'hFFEC00;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic model_reset();
        m_shown = 3'b000;
        m_level = FULL;
        m_phase = 0;
        m_bcnt  = 0;
        m_bph   = 1'b0;
    endtask

    task automatic apply_reset();
        exp_t ex;
        @(negedge clk);
        rst = 1'b1;
        ex = '0;
        sb_q.push_back(ex);
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel, queue its expected output, advance the model, wait one clk.
    task automatic drive(input bit vid, input int x, input int y, input logic [2:0] s,
                         input bit txt);
        exp_t        ex;
        logic [23:0] b;
        @(negedge clk);
        rst          = 1'b0;
        bus.video_on = vid;
        bus.x_coord  = 10'(x);
        bus.y_coord  = 10'(y);
        bus.S        = s;
        bus.text_on  = txt;
        ex = '0;
        if (vid) begin
            b      = sc24(raw_bkg(m_shown, y), m_level);
            ex.bkg = b;
            if (txt && ((m_shown == 3'b010) || ((m_shown == 3'b011) && m_bph)))
                ex.rgb = {3{sc(8'hFF, m_level)}};
            else
                ex.rgb = b;
        end
        sb_q.push_back(ex);
        if (vid && x == 639 && y == 479) begin
            if (m_bcnt == BF - 1) begin
                m_bcnt = 0;
                m_bph  = ~m_bph;
            end else begin
                m_bcnt++;
            end
            case (m_phase)
                0: if (s != m_shown) begin m_phase = 1; m_level--; end
                1: begin
                    if (m_level == 0) begin
                        m_shown = s;
                        m_phase = 2;
                        m_level = 1;
                    end else begin
                        m_level--;
                    end
                end
                default: begin
                    m_level++;
                    if (m_level == FULL) m_phase = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        e = sb_q.pop_front();
        n_cmp++;
        if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.bkg_rgb !== e.bkg) begin
            n_bad++;
            $display("FAIL reset: rgb=%h bkg=%h expected rgb=%h bkg=%h",
                     {bus.red, bus.green, bus.blue}, bus.bkg_rgb, e.rgb, e.bkg);
        end
    endtask

    task automatic test_on_bands();
        int ys[6];
        logic [23:0] want[6];
        ys   = '{50, 85, 86, 200, 416, 450};
        want = '{24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000, 24'hFF0000, 24'hFF0000};
        // Fade MENU -> ON: 16 eofs; frame 17 is steady.
        for (int f = 0; f < 17; f++) begin
            drive(1, 5, 100, ST_ON, 0);
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.bkg_rgb !== e.bkg) begin
                n_bad++;
                $display("FAIL on_fade_px f=%0d: rgb=%h bkg=%h expected rgb=%h bkg=%h", f,
                         {bus.red, bus.green, bus.blue}, bus.bkg_rgb, e.rgb, e.bkg);
            end
            drive(1, 639, 479, ST_ON, 0);
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.bkg_rgb !== e.bkg) begin
                n_bad++;
                $display("FAIL on_fade_eof f=%0d: rgb=%h bkg=%h expected rgb=%h bkg=%h", f,
                         {bus.red, bus.green, bus.blue}, bus.bkg_rgb, e.rgb, e.bkg);
            end
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 300, ys[i], ST_ON, 1);
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.red, bus.green, bus.blue} !== want[i] || bus.bkg_rgb !== want[i]
                || bus.bkg_rgb !== e.bkg) begin
                n_bad++;
                $display("FAIL on_band y=%0d: rgb=%h bkg=%h expected %h", ys[i],
                         {bus.red, bus.green, bus.blue}, bus.bkg_rgb, want[i]);
            end
        end
    endtask

    task automatic test_video_off();
        drive(0, 10, 10, ST_WIN, 1);
        e = sb_q.pop_front();
        n_cmp++;
        if ({bus.red, bus.green, bus.blue} !== 24'h0 || bus.bkg_rgb !== 24'h0
            || e.rgb !== 24'h0) begin
            n_bad++;
            $display("FAIL video_off: rgb=%h bkg=%h expected 0",
                     {bus.red, bus.green, bus.blue}, bus.bkg_rgb);
        end
    endtask

    task automatic test_fade();
        apply_reset();
        e = sb_q.pop_front();
        // S changes mid-frame: nothing moves until eof.
        drive(1, 5, 100, ST_LOSE, 0);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.bkg_rgb !== 24'h0000FF || bus.bkg_rgb !== e.bkg) begin
            n_bad++;
            $display("FAIL fade_hold: bkg=%h expected 0000ff", bus.bkg_rgb);
        end
        for (int f = 0; f < 17; f++) begin
            drive(1, 639, 479, ST_LOSE, 0);
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.bkg_rgb !== e.bkg) begin
                n_bad++;
                $display("FAIL fade_eof f=%0d: rgb=%h bkg=%h expected rgb=%h bkg=%h", f,
                         {bus.red, bus.green, bus.blue}, bus.bkg_rgb, e.rgb, e.bkg);
            end
            drive(1, 5, 100, ST_LOSE, 0);
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.bkg_rgb !== e.bkg) begin
                n_bad++;
                $display("FAIL fade_px f=%0d: rgb=%h bkg=%h expected rgb=%h bkg=%h", f,
                         {bus.red, bus.green, bus.blue}, bus.bkg_rgb, e.rgb, e.bkg);
            end
        end
        n_cmp++;
        if (bus.bkg_rgb !== 24'hFF0000) begin
            n_bad++;
            $display("FAIL fade_final: bkg=%h expected ff0000", bus.bkg_rgb);
        end
    endtask

    task automatic test_text();
        drive(1, 5, 100, ST_LOSE, 1);
        e = sb_q.pop_front();
        n_cmp++;
        if ({bus.red, bus.green, bus.blue} !== 24'hFFFFFF || bus.bkg_rgb !== 24'hFF0000
            || e.rgb !== 24'hFFFFFF) begin
            n_bad++;
            $display("FAIL text_lose: rgb=%h bkg=%h expected rgb=ffffff bkg=ff0000",
                     {bus.red, bus.green, bus.blue}, bus.bkg_rgb);
        end
        // Four eofs bring the fade-out to level 4.
        for (int f = 0; f < 4; f++) begin
            drive(1, 639, 479, ST_MENU, 1);
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.bkg_rgb !== e.bkg) begin
                n_bad++;
                $display("FAIL text_eof f=%0d: rgb=%h bkg=%h expected rgb=%h bkg=%h", f,
                         {bus.red, bus.green, bus.blue}, bus.bkg_rgb, e.rgb, e.bkg);
            end
        end
        drive(1, 5, 100, ST_MENU, 1);
        e = sb_q.pop_front();
        n_cmp++;
        if ({bus.red, bus.green, bus.blue} !== 24'h7F7F7F || bus.bkg_rgb !== 24'h7F0000
            || e.rgb !== 24'h7F7F7F) begin
            n_bad++;
            $display("FAIL text_half: rgb=%h bkg=%h expected rgb=7f7f7f bkg=7f0000",
                     {bus.red, bus.green, bus.blue}, bus.bkg_rgb);
        end
        // Text ignored once MENU is showing.
        for (int f = 0; f < 13; f++) begin
            drive(1, 639, 479, ST_MENU, 1);
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.bkg_rgb !== e.bkg) begin
                n_bad++;
                $display("FAIL text_rest f=%0d: rgb=%h bkg=%h expected rgb=%h bkg=%h", f,
                         {bus.red, bus.green, bus.blue}, bus.bkg_rgb, e.rgb, e.bkg);
            end
        end
    endtask

    task automatic test_blink();
        int n_white;
        n_white = 0;
        for (int f = 0; f < 17; f++) begin
            drive(1, 639, 479, ST_WIN, 0);
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.bkg_rgb !== e.bkg) begin
                n_bad++;
                $display("FAIL blink_fade f=%0d: rgb=%h bkg=%h expected rgb=%h bkg=%h", f,
                         {bus.red, bus.green, bus.blue}, bus.bkg_rgb, e.rgb, e.bkg);
            end
        end
        for (int f = 0; f < 8; f++) begin
            drive(1, 200, 200, ST_WIN, 1);
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.bkg_rgb !== 24'hFFEC00) begin
                n_bad++;
                $display("FAIL blink_txt f=%0d: rgb=%h bkg=%h expected rgb=%h bkg=ffec00", f,
                         {bus.red, bus.green, bus.blue}, bus.bkg_rgb, e.rgb);
            end
            if ({bus.red, bus.green, bus.blue} === 24'hFFFFFF) n_white++;
            drive(1, 639, 479, ST_WIN, 0);
            e = sb_q.pop_front();
        end
        n_cmp++;
        if (n_white !== 4) begin
            n_bad++;
            $display("FAIL blink_count: white frames=%0d expected 4", n_white);
        end
    endtask

    task automatic test_midfade();
        apply_reset();
        e = sb_q.pop_front();
        // MENU -> ON starts the fade; WIN requested partway through fade-out.
        for (int f = 0; f < 3; f++) begin
            drive(1, 639, 479, ST_ON, 0);
            e = sb_q.pop_front();
        end
        for (int f = 0; f < 6; f++) begin
            drive(1, 639, 479, ST_WIN, 0);
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.bkg_rgb !== e.bkg) begin
                n_bad++;
                $display("FAIL mid_eof f=%0d: rgb=%h bkg=%h expected rgb=%h bkg=%h", f,
                         {bus.red, bus.green, bus.blue}, bus.bkg_rgb, e.rgb, e.bkg);
            end
        end
        drive(1, 5, 100, ST_WIN, 0);
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.bkg_rgb !== 24'h1F1D00 || e.bkg !== 24'h1F1D00) begin
            n_bad++;
            $display("FAIL mid_swap: bkg=%h expected 1f1d00", bus.bkg_rgb);
        end
        for (int f = 0; f < 2; f++) begin
            drive(1, 639, 479, ST_WIN, 0);
            e = sb_q.pop_front();
        end
        apply_reset();
        e = sb_q.pop_front();
        n_cmp++;
        if ({bus.red, bus.green, bus.blue} !== 24'h0 || bus.bkg_rgb !== 24'h0) begin
            n_bad++;
            $display("FAIL mid_rst: rgb=%h bkg=%h expected 0",
                     {bus.red, bus.green, bus.blue}, bus.bkg_rgb);
        end
        drive(1, 5, 100, ST_WIN, 1);
        e = sb_q.pop_front();
        n_cmp++;
        if ({bus.red, bus.green, bus.blue} !== 24'h0000FF || bus.bkg_rgb !== 24'h0000FF) begin
            n_bad++;
            $display("FAIL mid_menu: rgb=%h bkg=%h expected 0000ff",
                     {bus.red, bus.green, bus.blue}, bus.bkg_rgb);
        end
    endtask

    initial begin
        bus.video_on = 1'b0;
        bus.x_coord  = '0;
        bus.y_coord  = '0;
        bus.S        = ST_MENU;
        bus.text_on  = 1'b0;
        model_reset();
        test_reset();
        test_on_bands();
        test_video_off();
        test_fade();
        test_text();
        test_blink();
        test_midfade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
